// File: rtl/hamming_frame_sequencer.sv
// ---------------------------------------------------------------------------
// hamming_frame_sequencer
//
// Frame-level controller in front of the Hamming(11,7) datapath.
// Collects 7-bit ASCII characters from an upstream valid/ready stream into a
// frame buffer of up to FRAME_LEN entries. When the frame closes (in_last or
// a full buffer), every buffered character is encoded to an even-parity
// Hamming(11,7) codeword and streamed out in order with sof/eof markers.
//
// Optional feature: define HAM_ERR_INJECT_EN to add the inj_en / inj_index /
// inj_pos inputs, which flip one codeword bit of a chosen word at load time.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     upstream character valid
//   in_ready     sequencer can accept a character (IDLE/FILL)
//   in_char      7-bit ASCII character
//   in_last      closes the frame after this character
//   out_valid    codeword valid
//   out_ready    downstream accepts codeword
//   out_code     codeword, bit k = code position k+1
//   out_index    0-based position of the codeword within the frame
//   out_sof      high with index 0
//   out_eof      high with the last word of the frame
//   frame_count  frames fully drained since reset (wraps)
//   busy         high whenever the sequencer is not IDLE
//   inj_en, inj_index, inj_pos   (HAM_ERR_INJECT_EN only) bit-error injection
// ---------------------------------------------------------------------------
module hamming_frame_sequencer #(
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_char,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_code,
    output logic [IDX_W-1:0] out_index,
    output logic             out_sof,
    output logic             out_eof,
    output logic [15:0]      frame_count,
    output logic             busy
`ifdef HAM_ERR_INJECT_EN
    ,
    input  logic             inj_en,
    input  logic [IDX_W-1:0] inj_index,
    input  logic [3:0]       inj_pos
`endif
);

    // One extra bit so the write counter can hold FRAME_LEN itself.
    localparam int                CNT_W       = IDX_W + 1;
    localparam logic [CNT_W-1:0]  FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ZERO_C      = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Even-parity Hamming(11,7): parity at positions 1,2,4,8; data
    // d0..d6 at positions 3,5,6,7,9,10,11. Returned bit k = position k+1.
    function automatic logic [10:0] ham_encode(input logic [6:0] d);
        logic p1;
        logic p2;
        logic p4;
        logic p8;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p4 = d[1] ^ d[2] ^ d[3];
        p8 = d[4] ^ d[5] ^ d[6];
        return {d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

`ifdef HAM_ERR_INJECT_EN
    // Single-bit flip mask for a 1-based code position; 0 and 12..15 are no-ops.
    function automatic logic [10:0] pos_mask(input logic [3:0] pos);
        logic [10:0] m;
        if ((pos >= 4'd1) && (pos <= 4'd11)) begin
            m = 11'd1 << (pos - 4'd1);
        end else begin
            m = 11'd0;
        end
        return m;
    endfunction
`endif

    state_t             state_r;
    state_t             state_next_s;
    logic [6:0]         char_buf_r [FRAME_LEN];
    logic [CNT_W-1:0]   wr_cnt_r;
    logic [CNT_W-1:0]   rd_ptr_r;
    logic               in_ready_r;
    logic               busy_r;
    logic               out_valid_r;
    logic               out_sof_r;
    logic               out_eof_r;
    logic [10:0]        out_code_r;
    logic [IDX_W-1:0]   out_index_r;
    logic [15:0]        frame_cnt_r;

    logic               in_fire_s;
    logic               out_fire_s;
    logic [CNT_W-1:0]   wr_cnt_inc_s;
    logic               close_s;
    logic               last_word_s;
    logic               load_first_s;
    logic               load_next_s;
    logic [CNT_W-1:0]   load_ptr_s;
    logic               load_eof_s;
    logic [10:0]        inj_mask_s;
    logic [10:0]        load_code_s;

    // Handshake decode and frame-close detection.
    always_comb begin
        in_fire_s    = in_valid && in_ready_r;
        out_fire_s   = out_valid_r && out_ready;
        wr_cnt_inc_s = wr_cnt_r + ONE_C;
        // A character that both carries in_last and fills the buffer closes once.
        close_s      = in_fire_s && (in_last || (wr_cnt_inc_s == FRAME_LEN_C));
        last_word_s  = ((rd_ptr_r + ONE_C) == wr_cnt_r);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (close_s) begin
                    state_next_s = ST_LOAD;
                end else if (in_fire_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (close_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_fire_s && last_word_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Selects and encodes the word to be registered into the output stage.
    // Word 0 is loaded in LOAD; each later word is loaded on the edge that
    // accepts its predecessor, which keeps the stream bubble-free.
    always_comb begin
        load_first_s = (state_r == ST_LOAD);
        load_next_s  = (state_r == ST_DRAIN) && out_fire_s && !last_word_s;
        if (load_first_s) begin
            load_ptr_s = ZERO_C;
        end else begin
            load_ptr_s = rd_ptr_r + ONE_C;
        end
        load_eof_s = ((load_ptr_s + ONE_C) == wr_cnt_r);
`ifdef HAM_ERR_INJECT_EN
        if (inj_en && (inj_index == load_ptr_s[IDX_W-1:0])) begin
            inj_mask_s = pos_mask(inj_pos);
        end else begin
            inj_mask_s = 11'd0;
        end
`else
        inj_mask_s = 11'd0;
`endif
        load_code_s = ham_encode(char_buf_r[load_ptr_s[IDX_W-1:0]]) ^ inj_mask_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame buffer; deliberately not reset, stale entries are never read.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            char_buf_r[wr_cnt_r[IDX_W-1:0]] <= in_char;
        end
    end

    // Counters, output stage and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_r    <= ZERO_C;
            rd_ptr_r    <= ZERO_C;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_eof_r   <= 1'b0;
            out_code_r  <= 11'd0;
            out_index_r <= {IDX_W{1'b0}};
            frame_cnt_r <= 16'd0;
        end else begin
            // Status flags follow the next state so they are registered.
            in_ready_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_FILL);
            busy_r     <= (state_next_s != ST_IDLE);
            if (in_fire_s) begin
                wr_cnt_r <= wr_cnt_inc_s;
            end
            if (load_first_s || load_next_s) begin
                out_valid_r <= 1'b1;
                out_code_r  <= load_code_s;
                out_index_r <= load_ptr_s[IDX_W-1:0];
                out_sof_r   <= load_first_s;
                out_eof_r   <= load_eof_s;
                rd_ptr_r    <= load_ptr_s;
            end else if ((state_r == ST_DRAIN) && out_fire_s) begin
                // Last word accepted: frame complete.
                out_valid_r <= 1'b0;
                out_sof_r   <= 1'b0;
                out_eof_r   <= 1'b0;
                frame_cnt_r <= frame_cnt_r + 16'd1;
                wr_cnt_r    <= ZERO_C;
                rd_ptr_r    <= ZERO_C;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign out_valid   = out_valid_r;
    assign out_code    = out_code_r;
    assign out_index   = out_index_r;
    assign out_sof     = out_sof_r;
    assign out_eof     = out_eof_r;
    assign frame_count = frame_cnt_r;

endmodule

// File: doc/hamming_frame_sequencer.md
Name: hamming_frame_sequencer

Overview:
- Frame-level controller in front of the Hamming(11,7) datapath.
- Collects 7-bit ASCII characters from an upstream valid/ready stream into a frame buffer of up to FRAME_LEN entries.
- Once the frame is closed, encodes each buffered character to an 11-bit codeword and streams the codewords out in order with frame markers.
- Replaces the current practice of presenting 16 parallel character buses to the encoder.

Parameters:
- FRAME_LEN, 16, maximum characters per frame; legal range 2..16.
- IDX_W, 4, width of out_index; must satisfy 2^IDX_W >= FRAME_LEN.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream character valid.
- in_ready  output  1  sequencer can accept a character.
- in_char  input  7  ASCII character, bit 0 = LSB.
- in_last  input  1  qualifies in_char; closes the frame after this character.
- out_valid  output  1  codeword valid.
- out_ready  input  1  downstream accepts codeword.
- out_code  output  11  Hamming codeword; bit k = code position k+1.
- out_index  output  IDX_W  position of the codeword within the frame, 0-based.
- out_sof  output  1  high with index 0.
- out_eof  output  1  high with the last word of the frame.
- frame_count  output  16  frames fully drained since reset; wraps at 0xFFFF to 0.
- busy  output  1  high when state != IDLE.

Behaviour:
- Handshakes:
  - A transfer occurs on a rising edge where valid and ready are both high.
  - out_* must hold stable while out_valid=1 and out_ready=0.
  - out_valid does not depend combinationally on out_ready.
- Reset (rst_n=0 at an edge), which takes effect in any state including mid-drain:
  - state=IDLE; wr_cnt=0; rd_ptr=0.
  - out_valid=0, out_sof=0, out_eof=0, out_code=0, out_index=0.
  - frame_count=0; busy=0.
  - in_ready=1 from the first cycle after reset releases.
  - Buffer contents are not cleared.
  - A partially filled or partially drained frame is discarded.
- States: IDLE, FILL, LOAD, DRAIN.
- IDLE and FILL (in_ready=1):
  - Each input transfer writes buf[wr_cnt] and increments wr_cnt.
  - IDLE moves to FILL on the first transfer.
  - The state goes to LOAD on the transfer that has in_last=1 or that makes wr_cnt reach FRAME_LEN.
  - If in_last=1 on the FRAME_LEN-th character, the frame closes once (no double close).
  - Frames are never empty; in_last always accompanies a real character.
- LOAD (in_ready=0):
  - One cycle; registers encode(buf[0]) into out_code.
  - Sets out_index=0, out_sof=1, out_eof=(wr_cnt==1), out_valid=1; next state DRAIN.
  - out_valid therefore rises on the 2nd edge after the closing input transfer.
- DRAIN (in_ready=0), on each output transfer:
  - If not the last word: load the next word (rd_ptr+1) on the same edge. Throughput is 1 word/cycle with no bubbles.
  - If the last word: out_valid=0, increment frame_count, clear wr_cnt and rd_ptr, go to IDLE; in_ready=1 the next cycle.
- Encoding (even parity, positions 1..11):
  - Parity at positions 1, 2, 4, 8.
  - Data d0..d6 at positions 3, 5, 6, 7, 9, 10, 11 respectively.
  - p1 = xor of positions 3, 5, 7, 9, 11.
  - p2 = xor of positions 3, 6, 7, 10, 11.
  - p4 = xor of positions 5, 6, 7.
  - p8 = xor of positions 9, 10, 11.
- in_valid during LOAD/DRAIN is ignored (no transfer, since in_ready=0).

Optional Feature:
- Macro HAM_ERR_INJECT_EN.
- When defined, adds inputs inj_en (1), inj_index (IDX_W) and inj_pos (4).
  - If inj_en=1 when the word with out_index==inj_index is loaded, bit inj_pos-1 of out_code is inverted.
  - inj_pos values 0 and 12..15 inject nothing.
  - The injection inputs are sampled at the load edge only.
- When not defined, the ports do not exist and codewords are always clean.

Test Plan:
- Full frame: 16 characters "Hello CoMP311-2!" back-to-back, out_ready=1 → 16 words, index 0..15, sof on 0, eof on 15, word0=0x4C8 ('H'=0x48), word1=0x62C ('e'=0x65), frame_count=1.
- Backpressure: same frame, out_ready toggled 1-0-0-1 pattern → no word lost or duplicated; out_code/out_index stable whenever stalled.
- Short frame: 'H', 'e', then 'l' with in_last=1 → 3 words, eof on index 2; in_ready low from LOAD until the cycle after the eof transfer; out_valid rises 2 edges after the closing transfer.
- Reset mid-drain: rst_n=0 for 1 cycle after word 5 of a 16-word frame → out_valid=0, frame_count=0, in_ready=1; a new 1-char frame 'H' with in_last yields a single word 0x4C8 with both sof and eof set.
- frame_count wrap: force 65535 drained frames (or preload via bench) → the next completed frame gives frame_count=0.
- HAM_ERR_INJECT_EN: inj_en=1, inj_index=0, inj_pos=3 on the 'H' frame → word0=0x4CC, other words unchanged; inj_pos=0 → word0=0x4C8.
